// File: rtl/fnn_pkg.sv
// Shared types and defaults for the fully-connected neuron datapath.
package fnn_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_FRAC_BITS = 12;

  typedef logic signed [DEF_DATA_W-1:0] fxp_t;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    RESULT,
    DONE
  } neuron_state_t;

endpackage

// File: rtl/fxp_saturate.sv
// Combinational bias-add, arithmetic rescale and clamp from accumulator width to DATA_W.
// Optional ReLU on the clamped result when NEURON_RELU_EN is defined.
module fxp_saturate #(
  parameter int                       ACC_W     = 37,
  parameter int                       DATA_W    = 16,
  parameter int                       FRAC_BITS = 12,
  parameter logic signed [DATA_W-1:0] BIAS      = '0
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] y
);

  // One extra bit so the bias add cannot wrap.
  localparam int SUM_W = ACC_W + 1;

  localparam logic signed [SUM_W-1:0] Y_MAX = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] Y_MIN = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] BIAS_Q =
    {{(SUM_W-DATA_W){BIAS[DATA_W-1]}}, BIAS} <<< FRAC_BITS;

  logic signed [SUM_W-1:0]  acc_ext;
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  shifted;
  logic signed [DATA_W-1:0] sat;

  assign acc_ext = {acc[ACC_W-1], acc};
  assign sum     = acc_ext + BIAS_Q;
  assign shifted = sum >>> FRAC_BITS;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    sat = shifted[DATA_W-1:0];
    if (shifted > Y_MAX) begin
      sat = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < Y_MIN) begin
      sat = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end

`ifdef NEURON_RELU_EN
  assign y = sat[DATA_W-1] ? '0 : sat;
`else
  assign y = sat;
`endif

endmodule

// File: rtl/neuron_mac.sv
// Single fully-connected neuron: streams activations, fetches weights, MACs, biases and saturates.
// Build option NEURON_RELU_EN clamps negative results to zero (handled in fxp_saturate).
module neuron_mac
  import fnn_pkg::*;
#(
  parameter int                       NUM_WEIGHT = 30,
  parameter int                       DATA_W     = DEF_DATA_W,
  parameter int                       FRAC_BITS  = DEF_FRAC_BITS,
  parameter logic signed [DATA_W-1:0] BIAS       = '0,
  parameter int                       ADDR_W     = $clog2(NUM_WEIGHT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     x_valid,
  output logic                     x_ready,
  output logic                     w_ren,
  output logic [ADDR_W-1:0]        w_radd,
  input  logic signed [DATA_W-1:0] w_data,
  output logic signed [DATA_W-1:0] y_out,
  output logic                     y_valid,
  input  logic                     y_ready
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + $clog2(NUM_WEIGHT);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHT - 1);

  neuron_state_t state, next_state;

  logic                     drain_cnt;
  logic [ADDR_W-1:0]        idx;
  logic                     accept;
  logic                     last_accept;
  logic                     x_d_valid;
  logic                     prod_valid;
  logic signed [DATA_W-1:0] x_d;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] sat_y;

  assign x_ready     = ((state == IDLE) || (state == ACCUM)) && !rst;
  assign accept      = x_valid && x_ready;
  assign last_accept = accept && (idx == LAST_IDX);
  assign w_ren       = accept;
  assign w_radd      = idx;
  assign y_valid     = (state == DONE);
  assign prod_ext    = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (last_accept) next_state = DRAIN;
               else if (accept) next_state = ACCUM;
      ACCUM:   if (last_accept) next_state = DRAIN;
      DRAIN:   if (drain_cnt)   next_state = RESULT;
      RESULT:                   next_state = DONE;
      DONE:    if (y_ready)     next_state = IDLE;
      default:                  next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      drain_cnt  <= 1'b0;
      idx        <= '0;
      x_d_valid  <= 1'b0;
      prod_valid <= 1'b0;
      acc        <= '0;
      y_out      <= '0;
    end else begin
      state      <= next_state;
      drain_cnt  <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      x_d_valid  <= accept;
      prod_valid <= x_d_valid;
      if (accept) begin
        idx <= last_accept ? '0 : idx + 1'b1;
      end
      if ((state == DONE) && y_ready) begin
        acc <= '0;
      end else if (prod_valid) begin
        acc <= acc + prod_ext;
      end
      if (state == RESULT) begin
        y_out <= sat_y;
      end
    end
  end

  // NOTE: datapath registers carry no reset; their valid bits above already gate every use.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_d <= x_in;
    end
    if (x_d_valid) begin
      prod <= x_d * w_data;
    end
  end

  fxp_saturate #(
    .ACC_W     (ACC_W),
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS),
    .BIAS      (BIAS)
  ) u_sat (
    .acc (acc),
    .y   (sat_y)
  );

endmodule
